// File: rtl/dfm_bus_responder_if.sv
// Request/response bundle between the pipeline data port (master)
// and the DFM responder (slave).
interface dfm_bus_responder_if #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32
);
    logic                        cpu_req_valid;
    logic                        cpu_req_ready;
    logic [ADDR_BUS_WIDTH-1:0]   cpu_req_addr;
    logic                        cpu_wr_en;
    logic [DATA_BUS_WIDTH-1:0]   cpu_wr_data;
    logic [DATA_BUS_WIDTH/8-1:0] cpu_wr_be;
    logic                        dfm_rsp_valid;
    logic [DATA_BUS_WIDTH-1:0]   dfm_rd_data;
    logic                        dfm_rsp_err;
    logic                        dfm_busy;

    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_wr_en, cpu_wr_data, cpu_wr_be,
        input  cpu_req_ready, dfm_rsp_valid, dfm_rd_data, dfm_rsp_err, dfm_busy
    );

    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_wr_en, cpu_wr_data, cpu_wr_be,
        output cpu_req_ready, dfm_rsp_valid, dfm_rd_data, dfm_rsp_err, dfm_busy
    );
endinterface

// File: rtl/dfm_bus_responder.sv
// DFM bus responder: accepts one load/store at a time, decodes the DFM
// region, accesses the local word array and returns a one-cycle response
// after WAIT_STATES extra cycles.
module dfm_bus_responder #(
    parameter int unsigned ADDR_BUS_WIDTH = 32,
    parameter int unsigned DATA_BUS_WIDTH = 32,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int unsigned WAIT_STATES    = 1,
    parameter logic [3:0]  REGION_TAG     = 4'b0001
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    dfm_bus_responder_if.slave bus
);

    localparam int unsigned BE_W      = DATA_BUS_WIDTH / 8;
    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  WS_LAST   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [26:0] DEPTH_LIM = 27'(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state, state_nxt;

    // Word storage; deliberately has no reset so a bench can preload it.
    logic [DATA_BUS_WIDTH-1:0] mem_map [0:MEM_DEPTH-1];

    // Request captured at accept.
    logic [ADDR_BUS_WIDTH-1:0] lat_addr;
    logic                      lat_wr_en;
    logic [DATA_BUS_WIDTH-1:0] lat_wr_data;
    logic [BE_W-1:0]           lat_wr_be;
    logic [3:0]                wait_cnt;

    // FSM control.
    logic req_ready;
    logic accept;
    logic enter_resp;

    // Request seen by the access logic at the RESP-entry edge.
    logic [ADDR_BUS_WIDTH-1:0] acc_addr;
    logic                      acc_wr_en;
    logic [DATA_BUS_WIDTH-1:0] acc_wr_data;
    logic [BE_W-1:0]           acc_wr_be;
    logic                      acc_hit;
    logic [IDX_W-1:0]          acc_idx;

    // Registered response.
    logic                      rsp_valid_q;
    logic [DATA_BUS_WIDTH-1:0] rd_data_q;
    logic                      rsp_err_q;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, ready and accept/RESP-entry strobes.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = !sys_rst;
                if (bus.cpu_req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt  = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WS_LAST) begin
                    state_nxt  = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // With no wait states the access happens on the accept edge itself, so
    // the live request is used there instead of the (not yet loaded) latch.
    always_comb begin
        if (accept) begin
            acc_addr    = bus.cpu_req_addr;
            acc_wr_en   = bus.cpu_wr_en;
            acc_wr_data = bus.cpu_wr_data;
            acc_wr_be   = bus.cpu_wr_be;
        end else begin
            acc_addr    = lat_addr;
            acc_wr_en   = lat_wr_en;
            acc_wr_data = lat_wr_data;
            acc_wr_be   = lat_wr_be;
        end
    end

    // Region decode: tag match, word aligned, full 26-bit index in range.
    always_comb begin
        acc_hit = (acc_addr[31:28] == REGION_TAG) &&
                  (acc_addr[1:0] == 2'b00) &&
                  ({1'b0, acc_addr[27:2]} < DEPTH_LIM);
        acc_idx = acc_addr[IDX_W+1:2];
    end

    // Request latch and wait-state counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lat_addr    <= '0;
            lat_wr_en   <= 1'b0;
            lat_wr_data <= '0;
            lat_wr_be   <= '0;
            wait_cnt    <= '0;
        end else if (accept) begin
            lat_addr    <= bus.cpu_req_addr;
            lat_wr_en   <= bus.cpu_wr_en;
            lat_wr_data <= bus.cpu_wr_data;
            lat_wr_be   <= bus.cpu_wr_be;
            wait_cnt    <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Byte-lane store on the RESP-entry edge; a reset on that edge drops it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && enter_resp && acc_hit && acc_wr_en) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (acc_wr_be[b]) begin
                    mem_map[acc_idx][8*b +: 8] <= acc_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Response registers: valid for exactly the RESP cycle, zero otherwise.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rsp_valid_q <= 1'b0;
            rd_data_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= enter_resp;
            rsp_err_q   <= enter_resp && !acc_hit;
            if (enter_resp && acc_hit && !acc_wr_en) begin
                rd_data_q <= mem_map[acc_idx];
            end else begin
                rd_data_q <= '0;
            end
        end
    end

    assign bus.cpu_req_ready = req_ready;
    assign bus.dfm_rsp_valid = rsp_valid_q;
    assign bus.dfm_rd_data   = rd_data_q;
    assign bus.dfm_rsp_err   = rsp_err_q;
    assign bus.dfm_busy      = (state != ST_IDLE);

    // A response strobe never lasts more than one cycle.
    a_rsp_one_cycle: assert property (@(posedge sys_clk) disable iff (sys_rst)
        rsp_valid_q |=> !rsp_valid_q);

    // Nothing is accepted while a transaction is outstanding.
    a_no_accept_busy: assert property (@(posedge sys_clk) disable iff (sys_rst)
        (state != ST_IDLE) |-> !accept);

endmodule

// File: tb/tb_dfm_bus_responder.sv
// Bench for dfm_bus_responder: three instances (0, 1 and 3 wait states)
// checked against a word-array model through an in-order response queue.
module tb_dfm_bus_responder;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    dfm_bus_responder_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) b0 ();
    dfm_bus_responder_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) b1 ();
    dfm_bus_responder_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) b3 ();

    dfm_bus_responder #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .MEM_DEPTH(1024),
                        .WAIT_STATES(0), .REGION_TAG(4'b0001))
        u_w0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b0));
    dfm_bus_responder #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .MEM_DEPTH(1024),
                        .WAIT_STATES(1), .REGION_TAG(4'b0001))
        u_w1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b1));
    dfm_bus_responder #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .MEM_DEPTH(1024),
                        .WAIT_STATES(3), .REGION_TAG(4'b0001))
        u_w3 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b3));

    // Expected response: which instance (0 -> u_w0, 1 -> u_w1, 2 -> u_w3),
    // data, error and the cyc value seen at the negedge where it must appear.
    typedef struct {
        int          sel;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [0:2][0:1023];

    function automatic int ws_of(input int s);
        case (s)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic rdy(input int s);
        case (s)
            0:       return b0.cpu_req_ready;
            1:       return b1.cpu_req_ready;
            default: return b3.cpu_req_ready;
        endcase
    endfunction

    function automatic logic [31:0] waddr(input int idx);
        logic [31:0] a;
        a = 32'h1000_0000 | (32'(idx) << 2);
        return a;
    endfunction

    task automatic set_req(input int s, input logic v, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] be);
        case (s)
            0: begin b0.cpu_req_valid = v; b0.cpu_req_addr = a; b0.cpu_wr_en = w;
                     b0.cpu_wr_data = d; b0.cpu_wr_be = be; end
            1: begin b1.cpu_req_valid = v; b1.cpu_req_addr = a; b1.cpu_wr_en = w;
                     b1.cpu_wr_data = d; b1.cpu_wr_be = be; end
            default: begin b3.cpu_req_valid = v; b3.cpu_req_addr = a; b3.cpu_wr_en = w;
                     b3.cpu_wr_data = d; b3.cpu_wr_be = be; end
        endcase
    endtask

    task automatic set_valid(input int s, input logic v);
        case (s)
            0:       b0.cpu_req_valid = v;
            1:       b1.cpu_req_valid = v;
            default: b3.cpu_req_valid = v;
        endcase
    endtask

    // Reference model: decode, update the word array, queue the response.
    task automatic push_exp(input int s, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] be, input int rcyc);
        exp_t x;
        logic hit;
        int   idx;
        hit   = (a[31:28] == 4'h1) && (a[1:0] == 2'b00) && (a[27:2] < 26'd1024);
        idx   = int'(a[11:2]);
        x.sel = s;
        x.cyc = rcyc;
        x.rd  = 32'h0;
        x.err = !hit;
        if (hit && w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[s][idx][8*b +: 8] = d[8*b +: 8];
        end else if (hit) begin
            x.rd = mdl[s][idx];
        end
        sbq.push_back(x);
    endtask

    // Drive one request (inputs change at negedge), wait for ready, and on
    // accept push the expectation. Returns at the negedge after the accept
    // edge; acc is the cyc value of that accept edge.
    task automatic issue(input int s, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] be,
                         input bit keep, input bit track, output int acc);
        int g;
        g   = 0;
        acc = -1;
        set_req(s, 1'b1, a, w, d, be);
        while (rdy(s) !== 1'b1) begin
            @(negedge sys_clk);
            g++;
            if (g > 64) begin
                total++;
                bad++;
                $display("FAIL issue_timeout dut=%0d addr=%h: ready never seen within 64 cycles", s, a);
                set_valid(s, 1'b0);
                return;
            end
        end
        acc = cyc + 1;
        if (track) push_exp(s, a, w, d, be, acc + ws_of(s));
        @(negedge sys_clk);
        if (!keep) set_valid(s, 1'b0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge sys_clk);
            #1;
            g++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want pending=0", sbq.size());
            sbq.delete();
        end
    endtask

    // Response monitor: pops the scoreboard on every response strobe.
    always @(negedge sys_clk) begin
        for (int s = 0; s < 3; s++) begin
            logic        v, r, e, bz;
            logic [31:0] d;
            exp_t        x;
            case (s)
                0: begin v = b0.dfm_rsp_valid; r = b0.cpu_req_ready; d = b0.dfm_rd_data;
                         e = b0.dfm_rsp_err; bz = b0.dfm_busy; end
                1: begin v = b1.dfm_rsp_valid; r = b1.cpu_req_ready; d = b1.dfm_rd_data;
                         e = b1.dfm_rsp_err; bz = b1.dfm_busy; end
                default: begin v = b3.dfm_rsp_valid; r = b3.cpu_req_ready; d = b3.dfm_rd_data;
                         e = b3.dfm_rsp_err; bz = b3.dfm_busy; end
            endcase
            if (v === 1'b1) begin
                total++;
                if (sbq.size() == 0 || sbq[0].sel != s) begin
                    bad++;
                    $display("FAIL rsp_unexpected dut=%0d got data=%h err=%b at cyc=%0d want no response",
                             s, d, e, cyc);
                end else begin
                    x = sbq.pop_front();
                    if (d !== x.rd || e !== x.err || cyc != x.cyc) begin
                        bad++;
                        $display("FAIL rsp_match dut=%0d got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d",
                                 s, d, e, cyc, x.rd, x.err, x.cyc);
                    end
                end
                total++;
                if (r !== 1'b0 || bz !== 1'b1) begin
                    bad++;
                    $display("FAIL rsp_handshake dut=%0d got ready=%b busy=%b want ready=0 busy=1", s, r, bz);
                end
            end
        end
    end

    task automatic test_reset();
        total++;
        if (b1.cpu_req_ready !== 1'b0 || b0.cpu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_in_reset got w1=%b w0=%b want 0", b1.cpu_req_ready, b0.cpu_req_ready);
        end
        sys_rst = 1'b0;
        #1;
        total++;
        if (b1.cpu_req_ready !== 1'b1 || b0.cpu_req_ready !== 1'b1 || b3.cpu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_after got %b%b%b want 111", b0.cpu_req_ready, b1.cpu_req_ready, b3.cpu_req_ready);
        end
        total++;
        if (b1.dfm_rsp_valid !== 1'b0 || b1.dfm_rd_data !== 32'h0 || b1.dfm_rsp_err !== 1'b0 ||
            b1.dfm_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b data=%h err=%b busy=%b want 0 0 0 0",
                     b1.dfm_rsp_valid, b1.dfm_rd_data, b1.dfm_rsp_err, b1.dfm_busy);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_load_basic();
        int acc;
        issue(1, 32'h1000_0014, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, acc);
        drain();
        total++;
        if (u_w1.mem_map[5] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL load_preload got=%h want=DEADBEEF", u_w1.mem_map[5]);
        end
        // Load: response must show up one edge after the accept edge (WS=1).
        issue(1, 32'h1000_0014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
        total++;
        if (b1.dfm_busy !== 1'b1 || b1.cpu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_busy got busy=%b ready=%b want busy=1 ready=0", b1.dfm_busy, b1.cpu_req_ready);
        end
        drain();
    endtask

    task automatic test_store_lanes();
        int acc;
        issue(1, 32'h1000_0008, 1'b1, 32'hAAAA_AAAA, 4'hF, 1'b0, 1'b1, acc);
        issue(1, 32'h1000_0008, 1'b1, 32'h1122_3344, 4'b0101, 1'b0, 1'b1, acc);
        drain();
        total++;
        if (u_w1.mem_map[2] !== 32'hAA22_AA44) begin
            bad++;
            $display("FAIL store_lanes got=%h want=AA22AA44", u_w1.mem_map[2]);
        end
        // Zero byte enables: a hit with a normal response and nothing written.
        issue(1, 32'h1000_0014, 1'b1, 32'h0123_4567, 4'h0, 1'b0, 1'b1, acc);
        issue(1, 32'h1000_0014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
        drain();
        total++;
        if (u_w1.mem_map[5] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL store_be_zero got=%h want=DEADBEEF", u_w1.mem_map[5]);
        end
    endtask

    task automatic test_miss();
        int          acc;
        logic [31:0] ma [3];
        ma[0] = 32'h2000_0000;
        ma[1] = 32'h1000_0002;
        ma[2] = 32'h1000_1000;
        issue(1, 32'h1000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            issue(1, ma[i], 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
            issue(1, ma[i], 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, acc);
        end
        drain();
        total++;
        if (u_w1.mem_map[0] !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL miss_no_write got=%h want=0BADF00D", u_w1.mem_map[0]);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int acc_prev;
        for (int i = 0; i < 4; i++)
            issue(0, waddr(i), 1'b1, 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0, 1'b1, acc);
        drain();
        // Valid held high throughout; each accept must be 2 edges after the last.
        acc_prev = -1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4)       issue(0, waddr(i), 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, acc);
            else if (i == 4) issue(0, waddr(7), 1'b1, 32'h7777_1234, 4'hF, 1'b1, 1'b1, acc);
            else             issue(0, waddr(7), 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
            if (acc_prev >= 0) begin
                total++;
                if (acc - acc_prev != 2) begin
                    bad++;
                    $display("FAIL b2b_spacing req=%0d got=%0d want=2", i, acc - acc_prev);
                end
            end
            acc_prev = acc;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int acc;
        issue(2, 32'h1000_0024, 1'b1, 32'h5555_5555, 4'hF, 1'b0, 1'b1, acc);
        drain();
        for (int k = 0; k < 2; k++) begin
            issue(2, 32'h1000_0024, 1'b1, (k == 0) ? 32'hFFFF_FFFF : 32'h1234_5678, 4'hF,
                  1'b0, 1'b0, acc);
            // k=0: reset during the first WAIT cycle; k=1: on the RESP-entry edge.
            if (k == 1) repeat (2) @(negedge sys_clk);
            sys_rst = 1'b1;
            @(negedge sys_clk);
            sys_rst = 1'b0;
            #1;
            total++;
            if (b3.cpu_req_ready !== 1'b1 || b3.dfm_busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_ready case=%0d got ready=%b busy=%b want 1 0",
                         k, b3.cpu_req_ready, b3.dfm_busy);
            end
            repeat (6) begin
                @(negedge sys_clk);
                total++;
                if (b3.dfm_rsp_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rstmid_no_rsp case=%0d got valid=%b want 0", k, b3.dfm_rsp_valid);
                end
            end
            total++;
            if (u_w3.mem_map[9] !== 32'h5555_5555) begin
                bad++;
                $display("FAIL rstmid_mem case=%0d got=%h want=55555555", k, u_w3.mem_map[9]);
            end
        end
    endtask

    task automatic test_random();
        int          acc;
        int          idx;
        int          kind;
        logic [31:0] a;
        logic [3:0]  t4;
        for (int i = 0; i < 24; i++) begin
            idx = (i < 16) ? i : 1000 + i;
            issue(1, waddr(idx), 1'b1, $urandom, 4'hF, 1'b0, 1'b1, acc);
        end
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 4) != 0) begin
                idx = $urandom_range(0, 23);
                if (idx >= 16) idx = 1000 + idx;
                a = waddr(idx);
            end else begin
                kind = $urandom_range(0, 2);
                t4   = 4'($urandom_range(0, 14));
                if (t4 >= 4'h1) t4 = t4 + 4'h1;
                case (kind)
                    0:       a = {t4, 26'($urandom), 2'b00};
                    1:       a = {4'h1, 26'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
                    default: a = {4'h1, 26'($urandom_range(1024, 67108863)), 2'b00};
                endcase
            end
            issue(1, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                  1'b0, 1'b1, acc);
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        end
        drain();
    endtask

    initial begin
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        repeat (3) @(negedge sys_clk);
        test_reset();
        test_load_basic();
        test_store_lanes();
        test_miss();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (4) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
